// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch FSM states, the NOP encoding and the
// default fetch-unit geometry.
package sisc_pkg;

  // Fetch unit is either idle or waiting on instruction memory.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  // All-zero instruction word is the architectural NOP.
  localparam logic [31:0] SISC_NOP = 32'h0000_0000;

  localparam int unsigned DEFAULT_ADDR_W      = 16;
  localparam int unsigned DEFAULT_RESET_PC    = 0;
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 15;

endpackage : sisc_pkg

// File: rtl/sisc_fetch_if.sv
// Instruction-memory request/acknowledge bus. The fetch unit is the
// master; the instruction memory is the slave.
interface sisc_fetch_if
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

  logic              mem_req;    // request held until acknowledged
  logic [ADDR_W-1:0] mem_addr;   // word address, stable while mem_req=1
  logic [31:0]       mem_rdata;  // instruction word, valid with mem_ack
  logic              mem_ack;    // one-cycle data-valid strobe

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );

endinterface : sisc_fetch_if

// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit. Owns the program counter, issues one
// outstanding request at a time to instruction memory, applies branch
// redirects (squashing an in-flight fetch if needed) and substitutes a
// NOP with a sticky fault flag when memory fails to answer in time.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT  // 1..255
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  sisc_fetch_if.master      imem,
  output logic [31:0]       ir,
  output logic              ir_load,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  localparam logic [7:0]        TIMEOUT_CNT = 8'(ACK_TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(1);

  fetch_state_t      state;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        ack_cnt;   // WAIT cycles elapsed without mem_ack
  logic [7:0]        cnt_inc;
  logic              squash;    // in-flight fetch was overtaken by a branch

  assign cnt_inc = ack_cnt + 8'd1;

  // Registered request lines drive the memory bus directly.
  assign imem.mem_req  = mem_req;
  assign imem.mem_addr = mem_addr;

  // Fetch FSM, program counter, timeout counter and instruction register.
  // NOTE: rst_f is sampled only on the clock edge (synchronous reset), and
  // all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= SISC_NOP;
      ir_load  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      busy     <= 1'b0;
      fault    <= 1'b0;
      ack_cnt  <= 8'd0;
      squash   <= 1'b0;
    end else begin
      ir_load <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // A branch in the same cycle as a fetch request fetches the target.
          if (fetch_en) begin
            state    <= S_WAIT;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            mem_addr <= br_taken ? br_addr : pc;
            ack_cnt  <= 8'd0;
            squash   <= 1'b0;
            if (br_taken) pc <= br_addr;
          end else if (br_taken) begin
            pc <= br_addr;
          end
        end

        S_WAIT: begin
          if (imem.mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            ack_cnt <= 8'd0;
            squash  <= 1'b0;
            if (squash || br_taken) begin
              // Stale instruction: drop it and keep the redirected pc.
              if (br_taken) pc <= br_addr;
            end else begin
              ir      <= imem.mem_rdata;
              ir_load <= 1'b1;
              pc      <= mem_addr + PC_STEP;
            end
          end else if (cnt_inc == TIMEOUT_CNT) begin
            // Memory never answered: hand the datapath a NOP and flag it.
            state   <= S_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            ack_cnt <= 8'd0;
            squash  <= 1'b0;
            ir      <= SISC_NOP;
            ir_load <= 1'b1;
            fault   <= 1'b1;
            if (br_taken) pc <= br_addr;
          end else begin
            ack_cnt <= cnt_inc;
            if (br_taken) begin
              squash <= 1'b1;
              pc     <= br_addr;
            end
          end
        end
      endcase
    end
  end

endmodule : sisc_fetch
